// File: rtl/ysyx_23060201_gpr_sb.sv
// General-purpose register file with a write-pending scoreboard and a reset scrub.
// After reset, each entry is zeroed in turn before rf_ready lets the core issue.
module ysyx_23060201_gpr_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RPORTS = 2,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             rf_ready,
  input  logic [NUM_RPORTS-1:0]            rd_en,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RPORTS-1:0]            rd_busy,
  input  logic                             issue_valid,
  input  logic [ADDR_WIDTH-1:0]            issue_rd,
  input  logic                             wb_valid,
  input  logic [ADDR_WIDTH-1:0]            wb_addr,
  input  logic [DATA_WIDTH-1:0]            wb_data,
  input  logic                             flush
);

  localparam int N = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

  typedef enum logic {
    S_SCRUB = 1'b0,
    S_READY = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [N-1:0]            busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   mem_q [N];
  logic                    wb_fire_s;
  logic                    issue_fire_s;
  logic [N-1:0]            wb_clr_s;
  logic [N-1:0]            issue_set_s;

  function automatic logic [N-1:0] onehot(input logic [ADDR_WIDTH-1:0] a);
    logic [N-1:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  // Writes and issues to x0 are dropped here, so entry 0 can never become busy or nonzero.
  assign wb_fire_s    = (state_q == S_READY) && wb_valid && (wb_addr != '0);
  assign issue_fire_s = (state_q == S_READY) && issue_valid && (issue_rd != '0);
  assign wb_clr_s     = wb_fire_s ? onehot(wb_addr) : '0;
  assign issue_set_s  = issue_fire_s ? onehot(issue_rd) : '0;
  assign rf_ready     = (state_q == S_READY);

  // State, scrub index and scoreboard registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_SCRUB;
      idx_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  // Next state: flush beats the wb clear, and an issue in the same cycle beats both.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    case (state_q)
      S_SCRUB: begin
        idx_d  = idx_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        busy_d = '0;
        if (idx_q == LAST_IDX) state_d = S_READY;
        else                   state_d = S_SCRUB;
      end
      S_READY: begin
        if (flush) busy_d = issue_set_s;
        else       busy_d = (busy_q & ~wb_clr_s) | issue_set_s;
      end
      default: begin
        state_d = S_SCRUB;
        idx_d   = '0;
        busy_d  = '0;
      end
    endcase
  end

  // Storage: scrub zeroes one entry per cycle; writeback lands only once ready.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == S_SCRUB) mem_q[idx_q] <= '0;
      else if (wb_fire_s)     mem_q[wb_addr] <= wb_data;
    end
  end

  for (genvar g = 0; g < NUM_RPORTS; g++) begin : g_rport
    logic [ADDR_WIDTH-1:0] addr_s;
    logic [DATA_WIDTH-1:0] data_s;
    logic                  busy_s;
    logic                  hit_s;

    assign addr_s = rd_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign hit_s  = BYPASS && wb_valid && (wb_addr == addr_s);

    // Read mux for this port.
    always_comb begin
      data_s = '0;
      busy_s = 1'b0;
      if ((state_q != S_READY) || !rd_en[g] || (addr_s == '0)) begin
        data_s = '0;
        busy_s = 1'b0;
      end else if (hit_s) begin
        data_s = wb_data;
        busy_s = 1'b0;
      end else begin
        data_s = mem_q[addr_s];
        busy_s = busy_q[addr_s];
      end
    end

    assign rd_data[g*DATA_WIDTH +: DATA_WIDTH] = data_s;
    assign rd_busy[g]                          = busy_s;
  end

endmodule
